pdp11_bus_ctl: RTL and testbench

Bus controller between the PDP-11 CPU core and the behavioral 2 KB RAM. It accepts one CPU read/write request at a time over a valid/ready handshake, and drives the RAM's address, write-enable, byte-mode and write-data ports. It returns read data or a bus-error code over a held response handshake. It detects odd-address word accesses and non-existent-memory (NXM) accesses, which the CPU turns into a trap to vector 4.

---
 rtl/pdp11_bus_ctl.sv | 166 ++++++++++++++++
 tb/tb_pdp11_bus_ctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_bus_ctl.sv
// rtl/pdp11_bus_ctl.sv - PDP-11 CPU to behavioural RAM bus controller
//
// Accepts one CPU request at a time (req_valid/req_ready), drives the RAM
// port, and returns read data or a bus-error code on a held response
// (rsp_valid/rsp_ready). Odd-address word accesses and accesses at or above
// MEM_BYTES (NXM) produce an error response instead of a RAM access.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr/req_write/req_byte/req_wdata   request fields
//   rsp_valid/rsp_ready        response handshake, response held until accepted
//   rsp_rdata/rsp_err          read data (byte reads zero-extended), 00 ok/01 odd/10 NXM
//   mem_addr/mem_we/mem_byte/mem_w   RAM drive
//   mem_d                      RAM read data, combinational from mem_addr
module pdp11_bus_ctl #(
  parameter int MEM_BYTES   = 2048,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [15:0] mem_w,
  input  logic [15:0] mem_d
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [1:0]  ERR_OK    = 2'b00;
  localparam logic [1:0]  ERR_ODD   = 2'b01;
  localparam logic [1:0]  ERR_NXM   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_NXM, S_RESP} state_t;

  state_t      state, state_n;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_write;
  logic        lat_byte;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] rdata_n;
  logic [1:0]  err_n;
  logic [15:0] rd_fmt;
  logic        accept;
  logic        is_odd;
  logic        is_nxm;
  logic        mem_active;

  assign accept = req_valid && req_ready;
  assign is_odd = !req_byte && req_addr[0];
  assign is_nxm = {16'h0000, req_addr} >= MEM_LIMIT;
  // The RAM right-aligns odd bytes, so a byte read only needs zero-extension.
  assign rd_fmt = lat_byte ? {8'h00, mem_d[7:0]} : mem_d;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rdata_n    = rsp_rdata;
    err_n      = rsp_err;
    req_ready  = (state == S_IDLE) && !reset;
    rsp_valid  = (state == S_RESP);
    // Gating with reset keeps a write whose ACCESS cycle meets reset off the RAM.
    mem_active = ((state == S_ACCESS) || (state == S_WAIT)) && !reset;
    mem_addr   = mem_active ? lat_addr : 16'h0000;
    mem_byte   = mem_active && lat_byte;
    mem_w      = mem_active ? lat_wdata : 16'h0000;
    mem_we     = mem_active && (state == S_ACCESS) && lat_write;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_odd) begin
            state_n = S_RESP;
            err_n   = ERR_ODD;
            rdata_n = 16'h0000;
          end else if (is_nxm) begin
            state_n = S_NXM;
            cnt_n   = 8'(TIMEOUT);
          end else begin
            state_n = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (lat_write) begin
          state_n = S_RESP;
          err_n   = ERR_OK;
          rdata_n = 16'h0000;
        end else if (WAIT_STATES == 0) begin
          state_n = S_RESP;
          err_n   = ERR_OK;
          rdata_n = rd_fmt;
        end else begin
          state_n = S_WAIT;
          cnt_n   = 8'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        // cnt counts the remaining wait cycles after this one; sample in the last.
        if (cnt == 8'd0) begin
          state_n = S_RESP;
          err_n   = ERR_OK;
          rdata_n = rd_fmt;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_NXM: begin
        // Loaded with TIMEOUT on entry, so this state lasts exactly TIMEOUT cycles.
        if (cnt <= 8'd1) begin
          state_n = S_RESP;
          err_n   = ERR_NXM;
          rdata_n = 16'h0000;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_n = S_IDLE;
          err_n   = ERR_OK;
          rdata_n = 16'h0000;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= ERR_OK;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      lat_write <= 1'b0;
      lat_byte  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      if (accept) begin
        lat_addr  <= req_addr;
        lat_write <= req_write;
        lat_byte  <= req_byte;
        lat_wdata <= req_byte ? {8'h00, req_wdata[7:0]} : req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_pdp11_bus_ctl.sv
// tb/tb_pdp11_bus_ctl.sv - self-checking bench for pdp11_bus_ctl
module tb_pdp11_bus_ctl;

  localparam int MEM_BYTES   = 2048;
  localparam int WAIT_STATES = 1;
  localparam int TIMEOUT     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_byte;
  logic [15:0] mem_w;
  logic [15:0] mem_d;

  int n_checks = 0;
  int n_errors = 0;

  // RAM seen by the DUT, and the reference model's own byte image.
  logic [7:0] ram [0:MEM_BYTES-1];
  logic [7:0] mm  [0:MEM_BYTES-1];

  pdp11_bus_ctl #(
    .MEM_BYTES(MEM_BYTES), .WAIT_STATES(WAIT_STATES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_byte(req_byte), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_w(mem_w), .mem_d(mem_d)
  );

  always #5 clk = ~clk;

  // Byte mode returns the addressed byte right-aligned with the other byte
  // of the word above it, so missing zero-extension shows up.
  always @* begin
    logic [10:0] ix;
    ix = mem_addr[10:0];
    if (mem_byte) mem_d = {ram[ix ^ 11'd1], ram[ix]};
    else          mem_d = {ram[ix | 11'd1], ram[ix & 11'h7FE]};
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byte) begin
        ram[mem_addr[10:0]] <= mem_w[7:0];
      end else begin
        ram[mem_addr[10:0] & 11'h7FE] <= mem_w[7:0];
        ram[mem_addr[10:0] | 11'd1]   <= mem_w[15:8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request and wait for it to be taken; returns just after the
  // accepting edge (cycle N).
  task automatic start_req(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_byte = b; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [15:0] a, input logic w, input logic b,
                        input logic [15:0] d, input int hold);
    logic        odd, nxm, ok;
    int          exp_lat, lat, we_n;
    logic [15:0] exp_rdata, exp_w;
    logic [1:0]  exp_err;
    logic [15:0] we_addr, we_w, hold_rdata;
    logic [1:0]  hold_err;
    logic        we_b, rr_bad, addr_bad, got, unstable;

    odd = !b && a[0];
    nxm = !odd && (32'(a) >= MEM_BYTES);
    ok  = !odd && !nxm;
    exp_err   = odd ? 2'b01 : (nxm ? 2'b10 : 2'b00);
    exp_lat   = odd ? 1 : (nxm ? 1 + TIMEOUT : (w ? 2 : 2 + WAIT_STATES));
    exp_rdata = 16'h0;
    if (ok && !w) exp_rdata = b ? {8'h00, mm[a]} : {mm[a + 1], mm[a]};
    exp_w = b ? {8'h00, d[7:0]} : d;

    start_req(a, w, b, d);
    lat = 0; got = 1'b0; we_n = 0; rr_bad = 1'b0; addr_bad = 1'b0;
    we_addr = 16'h0; we_w = 16'h0; we_b = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (req_ready) rr_bad = 1'b1;
      if (mem_we) begin
        we_n++; we_addr = mem_addr; we_w = mem_w; we_b = mem_byte;
      end
      if (!ok && (mem_addr != 16'h0)) addr_bad = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("mem_we_pulses", 32'(we_n), (ok && w) ? 32'd1 : 32'd0);
    check("mem_addr_idle_on_err", 32'(addr_bad), 32'd0);
    if (ok && w) begin
      check("we_addr", 32'(we_addr), 32'(a));
      check("we_data", 32'(we_w), 32'(exp_w));
      check("we_byte", 32'(we_b), 32'(b));
      if (b) begin
        mm[a] = d[7:0];
      end else begin
        mm[a] = d[7:0];
        mm[a + 1] = d[15:8];
      end
    end

    hold_rdata = rsp_rdata; hold_err = rsp_err; unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== hold_rdata || rsp_err !== hold_err) unstable = 1'b1;
      if (req_ready) rr_bad = 1'b1;
    end
    check("rsp_hold_stable", 32'(unstable), 32'd0);
    check("req_ready_busy", 32'(rr_bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_byte"}, 32'(mem_byte), 32'd0);
    check({tag, "_mem_w"}, 32'(mem_w), 32'd0);
  endtask

  initial begin
    logic [15:0] a, d;
    logic        w, b;
    int          r, diff;

    for (int i = 0; i < MEM_BYTES; i++) begin
      ram[i] = 8'h00;
      mm[i]  = 8'h00;
    end

    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    check("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Directed cases
    do_txn(16'h0010, 1'b1, 1'b0, 16'h1234, 0);
    do_txn(16'h0010, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(16'h0011, 1'b1, 1'b1, 16'hBEAB, 1);
    do_txn(16'h0010, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(16'h0010, 1'b1, 1'b0, 16'hCD12, 0);
    do_txn(16'h0011, 1'b0, 1'b1, 16'h0000, 2);
    do_txn(16'h0010, 1'b0, 1'b1, 16'h0000, 0);
    do_txn(16'h0003, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(16'h0005, 1'b1, 1'b0, 16'hFFFF, 0);
    do_txn(16'h0004, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(16'h0800, 1'b0, 1'b0, 16'h0000, 0);
    do_txn(16'h0801, 1'b0, 1'b1, 16'h0000, 0);
    do_txn(16'hFFFE, 1'b1, 1'b0, 16'h5555, 0);
    do_txn(16'h07FE, 1'b1, 1'b0, 16'hA5C3, 0);
    do_txn(16'h07FE, 1'b0, 1'b0, 16'h0000, 5);

    // Reset in the middle of an NXM timeout
    start_req(16'h0900, 1'b0, 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_nxm");
    reset = 1'b0;
    #1;
    check("rst_nxm_req_ready", 32'(req_ready), 32'd1);

    // Reset coinciding with a write's ACCESS cycle must suppress the write
    start_req(16'h0020, 1'b1, 1'b0, 16'h9876);
    @(negedge clk);
    check("rst_acc_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_acc_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    check_reset_outputs("rst_acc");
    reset = 1'b0;
    #1;
    check("rst_acc_req_ready", 32'(req_ready), 32'd1);
    do_txn(16'h0020, 1'b0, 1'b0, 16'h0000, 0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      a = 16'($urandom_range(0, MEM_BYTES - 1));
      if (r < 2) a = 16'($urandom_range(MEM_BYTES, 65535));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      if (!b && r >= 2 && r < 8) a[0] = 1'b0;
      do_txn(a, w, b, d, $urandom_range(0, 3));
    end

    diff = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== mm[i]) diff++;
    check("ram_image", 32'(diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
